bus_initiator: RTL
==================

Name: bus_initiator

Overview:
- Single-outstanding master for the daisy-chained register bus (addr/wdata/rdata/rw/valid, 16-bit fields).
- Accepts one request on a valid/ready front-end, launches it onto the head of the core chain, and waits for the transaction to return at the chain tail.
- Returns the captured read data, or a timeout status, on a valid/ready response port.
- Hardware replacement for the task-based initiator used in functional sims; sits between the host bridge and the first core.

Parameters:
- ADDR_WIDTH, 16, width of bus address.
- DATA_WIDTH, 16, width of bus wdata/rdata.
- TIMEOUT, 64, cycles after launch with no return before the transaction is abandoned; must be >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request.
- req_addr_i  input  ADDR_WIDTH  request address.
- req_wdata_i  input  DATA_WIDTH  write data; ignored for reads.
- req_rw_i  input  1  1 = write, 0 = read.
- addr_o  output  ADDR_WIDTH  bus address to chain head.
- wdata_o  output  DATA_WIDTH  bus write data to chain head.
- rdata_o  output  DATA_WIDTH  bus read data to chain head; always 0.
- rw_o  output  1  bus direction to chain head.
- valid_o  output  1  bus strobe to chain head.
- addr_i  input  ADDR_WIDTH  returned address from chain tail.
- wdata_i  input  DATA_WIDTH  returned write data; unused.
- rdata_i  input  DATA_WIDTH  returned read data from chain tail.
- rw_i  input  1  returned direction.
- valid_i  input  1  returned strobe from chain tail.
- resp_valid_o  output  1  response present.
- resp_ready_i  input  1  consumer takes response.
- resp_rdata_o  output  DATA_WIDTH  captured rdata_i; 0 on timeout.
- resp_rw_o  output  1  direction of completed request.
- resp_timeout_o  output  1  1 = no return within TIMEOUT.
- resp_mismatch_o  output  1  1 = returned addr_i/rw_i differ from the launched values.

Behaviour:
- Reset (async assert, sync release): state IDLE; req_ready_o=1; all bus outputs 0; resp_valid_o=0; all resp_* fields 0; timeout counter 0.
- IDLE:
  - req_ready_o=1.
  - On rising edge with req_valid_i=1, latch addr, wdata, rw and go to LAUNCH.
  - valid_i while in IDLE is ignored (late or stray return).
- LAUNCH:
  - Exactly one cycle; valid_o=1, addr_o/wdata_o/rw_o carry the latched request, rdata_o=0; req_ready_o=0.
  - Next state WAIT; counter cleared to 0.
  - Strobe timing: request accepted at edge N means valid_o is high only for the cycle between edges N and N+1.
- Outside LAUNCH: valid_o=0 and rw_o=0; addr_o/wdata_o hold the last values.
- WAIT:
  - Counter increments each cycle.
  - valid_i=1 in WAIT: capture rdata_i, set resp_rw_o to the latched rw, set resp_mismatch_o if addr_i != latched addr or rw_i != latched rw; resp_timeout_o=0; go to RESP.
  - Write responses also carry rdata_i as returned.
  - Counter reaches TIMEOUT-1 with no valid_i: resp_rdata_o=0, resp_timeout_o=1, resp_mismatch_o=0; go to RESP.
  - valid_i in the same cycle as expiry: the return wins and no timeout is reported.
  - Minimum latency: a return on the cycle after LAUNCH gives resp_valid_o one cycle later.
- RESP:
  - resp_valid_o=1 with all fields held stable until resp_valid_o & resp_ready_i at a rising edge, then go to IDLE.
  - No bypass: a new request is accepted no earlier than the cycle after the response handshake.
  - valid_i in RESP is ignored.
- One outstanding transaction only; no queuing. A return arriving after a timeout is discarded in IDLE/RESP.
- Reset mid-transaction: immediate return to reset values and in-flight response discarded. Any in-flight bus return after reset is ignored under the IDLE rule.

Test Plan:
- Read, 3-cycle loopback with a responder returning rdata=0x0004 for addr 0x0000: request read addr 0x0000 -> one-cycle valid_o with addr_o=0x0000, rw_o=0; resp_valid_o with rdata=0x0004, timeout=0, mismatch=0.
- Write then read: write 0x0003 to addr 0x0001, then read addr 0x0001 through a register model -> first response rw=1, second response rdata=0x0003.
- Timeout: chain never returns, TIMEOUT=8 -> resp_timeout_o=1 and rdata=0 exactly 8 cycles after LAUNCH. A return injected 2 cycles later is ignored; req_ready_o=1 after the response handshake.
- Backpressure: resp_ready_i held 0 for 5 cycles -> response fields stable, req_ready_o=0 throughout; a new req_valid_i is not accepted until the cycle after the handshake.
- Mismatch and race: return addr 0x0002 for a launch to 0x0001 -> mismatch=1. Separately, a return on the exact expiry cycle -> timeout=0.
- Reset: assert rst_n=0 during WAIT -> outputs at reset values in the same cycle; the later return is ignored and no resp_valid_o is produced.

Source files
------------

// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding master for the daisy-chained register bus.
// Launches one request at the chain head, waits for it at the tail, reports back.
module bus_initiator #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic                  req_rw_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_rw_o,
    output logic                  resp_timeout_o,
    output logic                  resp_mismatch_o
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_rw;
    logic [CW-1:0]         cnt;
    logic                  expire;
    logic                  unused_ok;

    // returned write data carries no information for the initiator
    assign unused_ok = ^wdata_i;

    assign expire = (cnt == LAST);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // next-state: the return strobe beats expiry on the same cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_valid_i) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (valid_i || expire) state_nxt = RESP;
            RESP:    if (resp_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // request latch; bus address/data hold their last values between launches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_rw    <= 1'b0;
        end else if (state == IDLE && req_valid_i) begin
            lat_addr  <= req_addr_i;
            lat_wdata <= req_wdata_i;
            lat_rw    <= req_rw_i;
        end
    end

    // cycles spent waiting for the return since launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 cnt <= '0;
        else if (state == LAUNCH)   cnt <= '0;
        else if (state == WAIT && !expire) cnt <= cnt + CW'(1);
    end

    // response capture on return or expiry; held through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_rdata_o    <= '0;
            resp_rw_o       <= 1'b0;
            resp_timeout_o  <= 1'b0;
            resp_mismatch_o <= 1'b0;
        end else if (state == WAIT) begin
            if (valid_i) begin
                resp_rdata_o    <= rdata_i;
                resp_rw_o       <= lat_rw;
                resp_timeout_o  <= 1'b0;
                resp_mismatch_o <= (addr_i != lat_addr) || (rw_i != lat_rw);
            end else if (expire) begin
                resp_rdata_o    <= '0;
                resp_rw_o       <= lat_rw;
                resp_timeout_o  <= 1'b1;
                resp_mismatch_o <= 1'b0;
            end
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign valid_o      = (state == LAUNCH);
    assign rw_o         = (state == LAUNCH) && lat_rw;
    assign addr_o       = lat_addr;
    assign wdata_o      = lat_wdata;
    assign rdata_o      = '0;
    assign resp_valid_o = (state == RESP);

endmodule
